// File: rtl/vga_timing.sv
// Raster timing generator for 1280x800@60: scan counters, sync/blank decode and a
// two-stage output pipeline that keeps RGB, hsync and vsync aligned at the pins.
module vga_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 64,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 200,
  parameter int V_ACTIVE = 800,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 24,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  output logic [10:0] draw_x,
  output logic [9:0]  draw_y,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_param_check
    $error("vga_timing: H_TOTAL/V_TOTAL exceed counter width");
  end

  // Constants are one bit wider than the counters so an end-of-range equal to 2^N still compares correctly.
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_reg, hcount_next;
  logic [9:0]  vcount_reg, vcount_next;
  logic [11:0] hcount_ext, hcount_next_ext;
  logic [10:0] vcount_ext, vcount_next_ext;
  logic        h_wrap;
  logic        de, hs, vs;
  logic        de_a_reg, hs_a_reg, vs_a_reg;
  logic        hs_pin_reg, vs_pin_reg, frame_tick_reg;
  logic [11:0] rgb_in;
  logic [11:0] rgb_pin_reg;

  always_comb begin
    hcount_ext  = {1'b0, hcount_reg};
    vcount_ext  = {1'b0, vcount_reg};
    h_wrap      = (hcount_ext == H_LAST);
    hcount_next = h_wrap ? 11'd0 : hcount_reg + 11'd1;
    vcount_next = vcount_reg;
    if (h_wrap) begin
      vcount_next = (vcount_ext == V_LAST) ? 10'd0 : vcount_reg + 10'd1;
    end
    hcount_next_ext = {1'b0, hcount_next};
    vcount_next_ext = {1'b0, vcount_next};
    de = (hcount_ext < H_ACT) && (vcount_ext < V_ACT);
    hs = (hcount_ext >= HS_START) && (hcount_ext < HS_END);
    vs = (vcount_ext >= VS_START) && (vcount_ext < VS_END);
  end

  // frame_tick looks at the next counter value so it rises together with draw_y reaching V_ACTIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_reg     <= '0;
      vcount_reg     <= '0;
      de_a_reg       <= 1'b0;
      hs_a_reg       <= 1'b0;
      vs_a_reg       <= 1'b0;
      hs_pin_reg     <= ~HS_POL;
      vs_pin_reg     <= ~VS_POL;
      frame_tick_reg <= 1'b0;
    end else begin
      hcount_reg     <= hcount_next;
      vcount_reg     <= vcount_next;
      de_a_reg       <= de;
      hs_a_reg       <= hs;
      vs_a_reg       <= vs;
      hs_pin_reg     <= hs_a_reg ? HS_POL : ~HS_POL;
      vs_pin_reg     <= vs_a_reg ? VS_POL : ~VS_POL;
      frame_tick_reg <= (hcount_next_ext == 12'd0) && (vcount_next_ext == V_ACT);
    end
  end

  assign rgb_in = {r_in, g_in, b_in};

  // Colour arrives one cycle after the counters, so it meets de_a and is blanked in the output stage.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    always_ff @(posedge clk) begin
      if (rst) begin
        rgb_pin_reg[gi*4 +: 4] <= 4'd0;
      end else begin
        rgb_pin_reg[gi*4 +: 4] <= de_a_reg ? rgb_in[gi*4 +: 4] : 4'd0;
      end
    end
  end

  assign draw_x     = hcount_reg;
  assign draw_y     = vcount_reg;
  assign vga_r      = rgb_pin_reg[11:8];
  assign vga_g      = rgb_pin_reg[7:4];
  assign vga_b      = rgb_pin_reg[3:0];
  assign vga_hs     = hs_pin_reg;
  assign vga_vs     = vs_pin_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_timing.sv
// Checks vga_timing (default and reduced geometry) cycle by cycle against an
// arithmetic raster model: position = elapsed cycles mod line/frame length.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic [3:0]  r0 = '0, g0 = '0, b0 = '0, r1 = '0, g1 = '0, b1 = '0;
  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic [3:0]  vr0, vg0, vb0, vr1, vg1, vb1;
  logic        hs0, vs0, ft0, hs1, vs1, ft1;

  vga_timing dut_full (
    .clk(clk), .rst(rst0), .r_in(r0), .g_in(g0), .b_in(b0),
    .draw_x(x0), .draw_y(y0), .vga_r(vr0), .vga_g(vg0), .vga_b(vb0),
    .vga_hs(hs0), .vga_vs(vs0), .frame_tick(ft0)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut_small (
    .clk(clk), .rst(rst1), .r_in(r1), .g_in(g1), .b_in(b1),
    .draw_x(x1), .draw_y(y1), .vga_r(vr1), .vga_g(vg1), .vga_b(vb1),
    .vga_hs(hs1), .vga_vs(vs1), .frame_tick(ft1)
  );

  int compared = 0;
  int mismatched = 0;

  // Geometry per instance: index 0 = default, 1 = reduced
  int ha[2] = '{1280, 8};
  int hf[2] = '{64, 2};
  int hw[2] = '{136, 2};
  int ht[2] = '{1680, 14};
  int va[2] = '{800, 4};
  int vf[2] = '{1, 1};
  int vw[2] = '{3, 1};
  int vt[2] = '{828, 7};
  bit hpol[2] = '{1'b0, 1'b0};
  bit vpol[2] = '{1'b1, 1'b1};

  int          p[2] = '{0, 0};
  int          last_tick[2] = '{-1, -1};
  logic [11:0] drv_col[2];
  int          mode = 0;
  logic [11:0] tab[0:2047];

  function automatic logic [11:0] colour(input int x);
    int xv;
    xv = x;
    case (mode)
      0:       return {xv[3:0], ~xv[3:0], xv[7:4]};
      1:       return tab[x];
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s inst=%0d p=%0d: got %0h expected %0h", tag, inst, p[inst], obs, exp);
    end
    if (mismatched > 40) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  endtask

  task automatic check(input int inst);
    int x, y, q, xq, yq;
    logic de;
    logic [11:0] exp_rgb, obs_rgb;
    logic exp_hs, exp_vs, exp_ft;
    logic [10:0] ox;
    logic [9:0] oy;
    logic ohs, ovs, oft;
    x = p[inst] % ht[inst];
    y = (p[inst] / ht[inst]) % vt[inst];
    exp_ft = (p[inst] > 0) && (x == 0) && (y == va[inst]);
    if (p[inst] < 2) begin
      exp_rgb = 12'h000;
      exp_hs  = ~hpol[inst];
      exp_vs  = ~vpol[inst];
    end else begin
      q  = p[inst] - 2;
      xq = q % ht[inst];
      yq = (q / ht[inst]) % vt[inst];
      de = (xq < ha[inst]) && (yq < va[inst]);
      exp_rgb = de ? drv_col[inst] : 12'h000;
      exp_hs = (xq >= ha[inst] + hf[inst] && xq < ha[inst] + hf[inst] + hw[inst]) ? hpol[inst] : ~hpol[inst];
      exp_vs = (yq >= va[inst] + vf[inst] && yq < va[inst] + vf[inst] + vw[inst]) ? vpol[inst] : ~vpol[inst];
    end
    if (inst == 0) begin
      ox = x0; oy = y0; obs_rgb = {vr0, vg0, vb0}; ohs = hs0; ovs = vs0; oft = ft0;
    end else begin
      ox = x1; oy = y1; obs_rgb = {vr1, vg1, vb1}; ohs = hs1; ovs = vs1; oft = ft1;
    end
    chk("draw_x", inst, 32'(ox), 32'(x));
    chk("draw_y", inst, 32'(oy), 32'(y));
    chk("rgb", inst, 32'(obs_rgb), 32'(exp_rgb));
    chk("vga_hs", inst, 32'(ohs), 32'(exp_hs));
    chk("vga_vs", inst, 32'(ovs), 32'(exp_vs));
    chk("frame_tick", inst, 32'(oft), 32'(exp_ft));
    if (oft === 1'b1) begin
      if (last_tick[inst] >= 0) chk("tick_period", inst, 32'(p[inst] - last_tick[inst]), 32'(ht[inst] * vt[inst]));
      last_tick[inst] = p[inst];
    end
  endtask

  // One clock for one instance: drive this cycle's inputs, clock, then check the new state.
  task automatic cycle(input int inst, input bit rst_now);
    logic [11:0] c;
    c = (p[inst] >= 1) ? colour((p[inst] - 1) % ht[inst]) : 12'h000;
    if (inst == 0) begin
      rst0 = rst_now; {r0, g0, b0} = c;
    end else begin
      rst1 = rst_now; {r1, g1, b1} = c;
    end
    @(posedge clk);
    #1;
    drv_col[inst] = c;
    if (rst_now) begin
      p[inst] = 0;
      last_tick[inst] = -1;
    end else begin
      p[inst] = p[inst] + 1;
    end
    check(inst);
  endtask

  task automatic run(input int inst, input int n);
    for (int i = 0; i < n; i++) cycle(inst, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) tab[i] = 12'($urandom);

    // Reduced geometry: two full frames with random colours
    mode = 1;
    cycle(1, 1'b1);
    run(1, 2 * 98 + 10);
    $display("phase small_frames: compared=%0d", compared);

    // Reset mid-frame at (5,2), then during the vsync pulse at the pins
    cycle(1, 1'b1);
    run(1, 2 * 14 + 5 - 1);
    cycle(1, 1'b1);
    run(1, 5 * 14 + 4 - 1);
    cycle(1, 1'b1);
    run(1, 2 * 98 + $urandom_range(0, 20));
    $display("phase small_resets: compared=%0d", compared);

    // Default geometry: alignment pattern r_in = x[3:0]
    mode = 0;
    cycle(0, 1'b1);
    run(0, 3 * 1680 + 20);
    $display("phase full_align: compared=%0d", compared);

    // Constant white input: blanking decides everything
    mode = 2;
    run(0, 1680);
    $display("phase full_blank: compared=%0d", compared);

    // Reset at draw_x=700 mid-line, then random colours
    mode = 1;
    cycle(0, 1'b1);
    run(0, 1680 + 700 - 1);
    cycle(0, 1'b1);
    run(0, 2 * 1680 + $urandom_range(0, 50));
    $display("phase full_reset: compared=%0d", compared);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator and pixel output stage for the VGA path. Scans the 1280x800@60 Hz frame, drives `draw_x`/`draw_y` to the pixel-colour logic, and takes that logic's registered 4-bit RGB back one cycle later. Outputs sync pulses and blanked RGB to the pins, aligned with each other. Also emits a once-per-frame tick that game logic uses to update object positions during vertical blanking.

## Interface
Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 64, horizontal front porch (clocks)
- H_SYNC, 136, hsync width (clocks)
- H_BP, 200, horizontal back porch; H_TOTAL = sum = 1680
- V_ACTIVE, 800, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 24, vertical back porch; V_TOTAL = sum = 828
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 1, vsync active level (1 = active-high)

Ports:
- clk  in  1  pixel clock (83.46 MHz nominal)
- rst  in  1  reset; one clock, synchronous, active-high
- r_in, g_in, b_in  in  4 each  pixel colour for the previous cycle's `draw_x`/`draw_y` (one-cycle registered latency upstream)
- draw_x  out  11  current horizontal count, 0..H_TOTAL-1
- draw_y  out  10  current vertical count, 0..V_TOTAL-1
- vga_r, vga_g, vga_b  out  4 each  blanked colour to DAC/pins
- vga_hs, vga_vs  out  1 each  sync to pins
- frame_tick  out  1  single-cycle pulse at start of vertical blanking

## Operation
- `hcount` (11 b) increments every clk. At H_TOTAL-1 it wraps to 0, and `vcount` (10 b) increments. `vcount` wraps to 0 after V_TOTAL-1 when `hcount` also wraps.
- `draw_x` = `hcount` and `draw_y` = `vcount`, both straight from registers. They are not clamped: blanking coordinates are visible to downstream logic.
- Combinational decode from the counters:
  - `de` = (hcount < H_ACTIVE) && (vcount < V_ACTIVE)
  - `hs` asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 1344..1479
  - `vs` asserted for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 801..803, over whole lines
- Stage A registers `de`, `hs`, `vs`. This aligns them with `r_in`/`g_in`/`b_in`.
- Stage B (output registers):
  - `vga_r` <= de_a ? r_in : 0, and likewise for g and b.
  - `vga_hs` <= hs_a ? HS_POL : ~HS_POL, and likewise for vs.
- `frame_tick` is registered. It is high for exactly one cycle when hcount==0 && vcount==V_ACTIVE, i.e. the first cycle of line 800.
- Counter width rule: all compares are unsigned. Parameter sums must fit the counter widths (H_TOTAL <= 2048, V_TOTAL <= 1024); this is an elaboration-time check.

## Timing
- Reset values after the first clk edge with rst=1:
  - hcount = vcount = 0, so draw_x = 0 and draw_y = 0
  - stage A: de_a = 0, hs_a = 0, vs_a = 0 (deasserted)
  - vga_r/g/b = 0, vga_hs = ~HS_POL (1), vga_vs = ~VS_POL (0), frame_tick = 0
- Reset mid-frame:
  - Counters and both pipeline stages return to the reset values above on the next edge, regardless of position.
  - No partial sync pulse is extended; hs/vs deassert on the same edge.
- First cycle after rst falls: draw_x=0, draw_y=0. vga_* shows pixel (0,0) colour 2 cycles later.
- Latency from counter value to pins is 2 clk for RGB, hs and vs alike, so all pin outputs stay mutually aligned.
- `frame_tick` tracks counter time, not pin time: it is 0-cycle relative to draw_y becoming 800.
- Simultaneous hcount and vcount wrap at (1679, 827) gives (0, 0) on the next edge, with no extra cycle.
- Frame period is exactly H_TOTAL*V_TOTAL = 1,391,040 clk. Line period is 1680 clk.
- The hs pulse is 136 clk at the pins; the vs pulse is 3*1680 = 5040 clk.

## Test plan
- Reset then run 2 frames with default parameters:
  - draw_x sequence is 0..1679 repeating, and draw_y increments only on the x wrap.
  - Frame period is 1,391,040 clk, and frame_tick fires once per frame when draw_y becomes 800.
- Sync check:
  - vga_hs is low for exactly 136 clk, falling 2 clk after draw_x=1344.
  - vga_vs is high for 5040 clk, rising 2 clk after (draw_x=0, draw_y=801).
- Blanking: drive r_in=g_in=b_in=4'hF constantly.
  - vga_rgb is 0xF exactly when the delayed (x<1280 && y<800) holds, and 0 otherwise, including x=1280 and y=800.
- Alignment: r_in = registered (draw_x[3:0]) models upstream latency.
  - At the pins, the first visible pixel of each line shows 0, and pixel 1279 shows 0xF.
- Mid-frame reset at (draw_x=700, draw_y=400), and again during an active vsync pulse:
  - Next cycle draw_x=0, draw_y=0, vga_hs=1, vga_vs=0, RGB=0.
  - Clean frame restarts after release.
- Small parameters for fast sim (H 8/2/2/2, V 4/1/1/1):
  - H_TOTAL=14, V_TOTAL=7.
  - Check the wrap at (13,6)->(0,0) and frame_tick at (0,4).
